// File: rtl/week_day_counter_pkg.sv
// week_day_counter_pkg
// Weekday codes, FSM state encoding and the weekday increment helper.
// Shared by week_day_counter and the weekday 7-segment pattern decoder.
package week_day_counter_pkg;

  localparam logic [3:0] WD_SU  = 4'd0;
  localparam logic [3:0] WD_MO  = 4'd1;
  localparam logic [3:0] WD_TU  = 4'd2;
  localparam logic [3:0] WD_WE  = 4'd3;
  localparam logic [3:0] WD_TH  = 4'd4;
  localparam logic [3:0] WD_FR  = 4'd5;
  localparam logic [3:0] WD_SA  = 4'd6;
  localparam logic [3:0] WD_MAX = WD_SA;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  // SA wraps to SU; an illegal code (7..15) also lands on SU.
  function automatic logic [3:0] wd_inc(input logic [3:0] wd);
    return (wd >= WD_MAX) ? WD_SU : wd + 4'd1;
  endfunction

endpackage

// File: rtl/week_day_counter_btn_debounce.sv
// btn_debounce
// 2-FF synchronizer, counting debouncer and rising-edge detector for one
// raw push button.
//   CLK, RSTn  : clock, async active-low reset
//   btn_raw    : raw asynchronous active-high button
//   btn_level  : debounced level
//   btn_press  : one-cycle pulse on a debounced rising edge
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1, sync2;
  logic          deb_prev;
  logic          armed;
  logic [CW-1:0] cnt;

  // armed stays low after reset until the synced level has been stably low
  // for DEB_CYCLES samples, so a button held through reset cannot fire.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_prev  <= 1'b0;
      armed     <= 1'b0;
      btn_level <= 1'b0;
      cnt       <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      deb_prev <= btn_level;
      if ((armed && (sync2 == btn_level)) || (!armed && sync2)) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt       <= '0;
        btn_level <= sync2;
        armed     <= 1'b1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign btn_press = btn_level & ~deb_prev;

endmodule

// File: rtl/week_day_counter.sv
// week_day_counter
// Weekday counter (0=SU..6=SA) advanced by the midnight carry, settable with
// a mode and an up button, with a blink flag while setting.
//   CLK, RSTn  : clock, async active-low reset
//   day_carry  : one-cycle midnight rollover pulse
//   btn_mode   : raw button, toggles RUN/SET
//   btn_up     : raw button, increments weekday in SET
//   week_day   : weekday code 0..6
//   set_mode   : high in SET
//   blank      : display off (blink phase in SET)
//   week_carry : one-cycle pulse on SA -> SU in RUN
module week_day_counter
  import week_day_counter_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_HALF = 12500000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       day_carry,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [3:0] week_day,
  output logic       set_mode,
  output logic       blank,
  output logic       week_carry
);

  localparam int BW = $clog2(BLINK_HALF);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t        state_q, state_d;
  logic          mode_press, up_press;
  logic [1:0]    lvl_unused;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          run_inc, set_inc;
  logic [3:0]    wd_d;
  logic          wc_d, blank_d;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .btn_raw   (btn_mode),
    .btn_level (lvl_unused[0]),
    .btn_press (mode_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .btn_raw   (btn_up),
    .btn_level (lvl_unused[1]),
    .btn_press (up_press)
  );

  always_comb begin
    state_d     = state_q;
    wd_d        = week_day;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    run_inc     = (state_q == ST_RUN) && day_carry;
    set_inc     = (state_q == ST_SET) && up_press;
    if (run_inc || set_inc) wd_d = wd_inc(week_day);
    wc_d = run_inc && (week_day == WD_MAX);
    if (mode_press) state_d = (state_q == ST_RUN) ? ST_SET : ST_RUN;
    // Counter is held clear outside SET, on SET entry and on every edit,
    // so each of those starts with a visible half-period.
    if ((state_q != ST_SET) || (state_d != ST_SET) || up_press) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
    blank_d = (state_d == ST_SET) && phase_d;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_RUN;
      week_day    <= WD_SU;
      week_carry  <= 1'b0;
      blank       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      week_day    <= wd_d;
      week_carry  <= wc_d;
      blank       <= blank_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign set_mode = (state_q == ST_SET);

endmodule
